// File: rtl/regfile_32x32_pkg.sv
// ----------------------------------------------------------------------------
// regfile_32x32_pkg
// Shared CPU datapath constants. The operand muxes, ALU and decoder use the
// same values, so they are defined once here.
//   REG_W     register width in bits
//   REG_AW    register index width
//   REG_DEPTH number of architectural registers (2**REG_AW)
//   REG_ZERO  index of the hard-wired zero register
// ----------------------------------------------------------------------------
package regfile_32x32_pkg;

    localparam int             REG_W     = 32;
    localparam int             REG_AW    = 5;
    localparam int             REG_DEPTH = 1 << REG_AW;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_W-1:0]  reg_word_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/dffe32.sv
// ----------------------------------------------------------------------------
// dffe32
// W-bit D flip-flop with load enable and asynchronous active-low clear.
// One instance holds one architectural register of the register file.
// Ports:
//   Clk   rising-edge clock
//   Clrn  asynchronous active-low clear (Q -> 0 immediately)
//   En    load enable, sampled on rising Clk
//   D     load data
//   Q     stored value
// ----------------------------------------------------------------------------
module dffe32
    import regfile_32x32_pkg::*;
#(
    parameter int W = REG_W
) (
    input  logic         Clk,
    input  logic         Clrn,
    input  logic         En,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    logic [W-1:0] r_q;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_q <= '0;
        end else if (En) begin
            r_q <= D;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/regfile_32x32.sv
// ----------------------------------------------------------------------------
// regfile_32x32
// General-purpose register file for the CPU datapath: two combinational read
// ports, one synchronous write port, register 0 hard-wired to zero.
// Ports:
//   Clk   rising-edge clock
//   Clrn  asynchronous active-low reset, clears all registers
//   Ra    read port A index            Qa  read data A (combinational)
//   Rb    read port B index            Qb  read data B (combinational)
//   We    write enable                 Wn  write index
//   D     write data
// Parameters:
//   DATA_W register width, ADDR_W index width,
//   BYPASS 1: a write in flight is forwarded to matching reads in the same
//          cycle; 0: reads return the stored value only.
// ----------------------------------------------------------------------------
module regfile_32x32
    import regfile_32x32_pkg::*;
#(
    parameter int DATA_W = REG_W,
    parameter int ADDR_W = REG_AW,
    parameter int BYPASS = 1
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    input  logic              We,
    input  logic [ADDR_W-1:0] Wn,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Qa,
    output logic [DATA_W-1:0] Qb
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

    // Decoded write enables; index 0 has no storage, so no enable bit exists.
    logic [DEPTH-1:1]  w_wen;
    logic [DATA_W-1:0] w_q [DEPTH];
    logic              w_wr_valid;
    logic              w_byp_a;
    logic              w_byp_b;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    always_comb begin
        w_wen = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (We && (Wn == ADDR_W'(i))) begin
                w_wen[i] = 1'b1;
            end
        end
    end

    assign w_q[0] = '0;

    for (genvar g = 1; g < DEPTH; g++) begin : g_reg
        dffe32 #(
            .W (DATA_W)
        ) u_reg (
            .Clk  (Clk),
            .Clrn (Clrn),
            .En   (w_wen[g]),
            .D    (D),
            .Q    (w_q[g])
        );
    end

    // Stored-value read; index 0 is forced to zero rather than relying on
    // the constant entry so the zero register never depends on the mux.
    assign w_rd_a = (Ra == IDX_ZERO) ? '0 : w_q[Ra];
    assign w_rd_b = (Rb == IDX_ZERO) ? '0 : w_q[Rb];

    // Forwarding is gated by Clrn so both ports read zero throughout reset,
    // even with a write request pending.
    assign w_wr_valid = (BYPASS != 0) && Clrn && We && (Wn != IDX_ZERO);
    assign w_byp_a    = w_wr_valid && (Wn == Ra);
    assign w_byp_b    = w_wr_valid && (Wn == Rb);

    assign Qa = w_byp_a ? D : w_rd_a;
    assign Qb = w_byp_b ? D : w_rd_b;

endmodule

// File: tb/tb_regfile_32x32.sv
module tb_regfile_32x32;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic [4:0]  Ra, Rb, Wn;
    logic        We;
    logic [31:0] D;
    logic [31:0] qa1, qb1, qa0, qb0;

    typedef struct {
        string       tag;
        logic [31:0] qa1;
        logic [31:0] qb1;
        logic [31:0] qa0;
        logic [31:0] qb0;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m [32];
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    regfile_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .Clk (Clk), .Clrn (Clrn), .Ra (Ra), .Rb (Rb),
        .We (We), .Wn (Wn), .D (D), .Qa (qa1), .Qb (qb1)
    );

    regfile_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nobyp (
        .Clk (Clk), .Clrn (Clrn), .Ra (Ra), .Rb (Rb),
        .We (We), .Wn (Wn), .D (D), .Qa (qa0), .Qb (qb0)
    );

    function automatic logic [31:0] model_rd(input logic [4:0] idx, input bit byp);
        if (Clrn !== 1'b1) return 32'h0;
        if (byp && We && (Wn != 5'd0) && (Wn == idx)) return D;
        if (idx == 5'd0) return 32'h0;
        return m[idx];
    endfunction

    task automatic clr_model();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.qa1 = model_rd(Ra, 1'b1);
        e.qb1 = model_rd(Rb, 1'b1);
        e.qa0 = model_rd(Ra, 1'b0);
        e.qb0 = model_rd(Rb, 1'b0);
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (qa1 === e.qa1) else begin
            errors++;
            $error("FAIL %s qa_byp ra=%0d observed %h expected %h", e.tag, Ra, qa1, e.qa1);
        end
        checks++;
        assert (qb1 === e.qb1) else begin
            errors++;
            $error("FAIL %s qb_byp rb=%0d observed %h expected %h", e.tag, Rb, qb1, e.qb1);
        end
        checks++;
        assert (qa0 === e.qa0) else begin
            errors++;
            $error("FAIL %s qa_nobyp ra=%0d observed %h expected %h", e.tag, Ra, qa0, e.qa0);
        end
        checks++;
        assert (qb0 === e.qb0) else begin
            errors++;
            $error("FAIL %s qb_nobyp rb=%0d observed %h expected %h", e.tag, Rb, qb0, e.qb0);
        end
    endtask

    // Expectation is queued when the inputs are applied, compared once the
    // combinational read has settled.
    task automatic look(input string tag);
        push_exp(tag);
        #1;
        pop_chk();
    endtask

    task automatic drive(input logic we, input logic [4:0] wn, input logic [31:0] d,
                         input logic [4:0] ra, input logic [4:0] rb);
        @(negedge Clk);
        We = we;
        Wn = wn;
        D  = d;
        Ra = ra;
        Rb = rb;
    endtask

    task automatic tick();
        @(posedge Clk);
        if ((Clrn === 1'b1) && We && (Wn != 5'd0)) m[Wn] = D;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Clrn = 1'b0;
        We   = 1'b0;
        Wn   = 5'd0;
        D    = 32'h0;
        Ra   = 5'd0;
        Rb   = 5'd0;
        clr_model();

        // reset state
        repeat (2) @(negedge Clk);
        look("rst_idx0");
        Ra = 5'd17; Rb = 5'd31;
        look("rst_hi");
        @(negedge Clk);
        Clrn = 1'b1;

        // write / read
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        look("wr5_rd5_rd6");
        checks++;
        assert (qa1 === 32'hDEADBEEF) else begin
            errors++;
            $error("FAIL wr5_literal observed %h expected %h", qa1, 32'hDEADBEEF);
        end

        // zero register
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        look("zero_wr_pending");
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        look("zero_reg");

        // bypass
        drive(1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
        look("bypass_pre");
        checks++;
        assert ((qa1 === 32'h2) && (qa0 === 32'h1)) else begin
            errors++;
            $error("FAIL bypass_literal observed %h/%h expected 00000002/00000001", qa1, qa0);
        end
        tick();
        look("bypass_post_edge");
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        look("bypass_after");

        // write enable low, back-to-back writes
        drive(1'b0, 5'd9, 32'h1234, 5'd9, 5'd9);
        tick();
        drive(1'b0, 5'd9, 32'h1234, 5'd9, 5'd9);
        look("we0_no_write");
        drive(1'b1, 5'd31, 32'hA, 5'd31, 5'd0);
        tick();
        drive(1'b1, 5'd31, 32'hB, 5'd31, 5'd31);
        look("b2b_second_pending");
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd7);
        look("b2b31");

        // asynchronous reset mid-cycle, bypass gated by reset
        drive(1'b1, 5'd5, 32'h55AA55AA, 5'd5, 5'd7);
        #1;
        Clrn = 1'b0;
        clr_model();
        look("rst_bypass_gate");
        We = 1'b0;
        for (int i = 0; i < 32; i++) begin
            Ra = 5'(i);
            Rb = 5'(31 - i);
            look("rst_async_all");
        end

        // write during reset is discarded
        drive(1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3);
        look("rst_wr_pending");
        tick();
        @(negedge Clk);
        We = 1'b0;
        Clrn = 1'b1;
        Ra = 5'd3; Rb = 5'd5;
        look("wr_during_rst");

        // sweep: fill every register then read all pairs
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'd0);
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                Ra = 5'(a);
                Rb = 5'(b);
                look("sweep_pairs");
            end
        end

        // sweep again with random reset pulses between edges
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i),
                  5'($urandom_range(0, 31)));
            look("rsweep_pre");
            if ($urandom_range(0, 3) == 0) begin
                #1;
                Clrn = 1'b0;
                clr_model();
                look("rsweep_pulse");
                Clrn = 1'b1;
            end
            tick();
            #1;
            look("rsweep_post");
        end
        for (int n = 0; n < 60; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'($urandom),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) Ra = Wn;
            look("rand_pre");
            if ($urandom_range(0, 4) == 0) begin
                #1;
                Clrn = 1'b0;
                clr_model();
                look("rand_pulse");
                Clrn = 1'b1;
            end
            tick();
            #1;
            look("rand_post");
        end
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++) begin
            Ra = 5'(a);
            Rb = 5'(31 - a);
            look("final_read");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
